// File: rtl/cpu_host_loader.sv
`timescale 1ns/1ps
// cpu_host_loader: preloads CPU data memory over a valid/ready word stream while the
// CPU is held in reset, then runs the CPU until it flags completion or times out.
module cpu_host_loader #(
  parameter logic [31:0] RESULT_ADDR    = 32'h0200_0004,
  parameter logic [31:0] DONE_ADDR      = 32'h0200_0008,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        done,
  output logic        timeout,
  output logic        addr_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    GAP,
    FLUSH0,
    FLUSH1,
    RUN
  } stateT;

  stateT state, nextState;

  logic [31:0]     addrReg;
  logic [31:0]     dataReg;
  logic            lastReg;
  logic [CntW-1:0] runCnt;
  logic            resultHit;
  logic            doneHit;
  logic            cntHit;

  assign resultHit = MemWrite && (DataAdr == RESULT_ADDR);
  assign doneHit   = MemWrite && (DataAdr == DONE_ADDR) && (WriteData == 32'd1);
  // The counter register reaches TIMEOUT_CYCLES on the aborting edge, so RUN lasts
  // exactly TIMEOUT_CYCLES cycles.
  assign cntHit    = (runCnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = LOAD;
      LOAD:    if (ld_valid) nextState = WRITE;
      WRITE:   nextState = GAP;
      GAP:     nextState = lastReg ? FLUSH0 : LOAD;
      FLUSH0:  nextState = FLUSH1;
      FLUSH1:  nextState = RUN;
      RUN:     if (doneHit || cntHit) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Everything below is decoded from the state register and registered data only.
  assign ld_ready      = (state == LOAD);
  assign busy          = (state != IDLE);
  assign cpu_reset     = (state != RUN);
  assign Ext_MemWrite  = (state == WRITE);
  assign Ext_DataAdr   = Ext_MemWrite ? {addrReg[31:2], 2'b00} : '0;
  assign Ext_WriteData = Ext_MemWrite ? dataReg : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrReg      <= '0;
      dataReg      <= '0;
      lastReg      <= 1'b0;
      runCnt       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            addr_err     <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            addrReg <= ld_addr;
            dataReg <= ld_data;
            lastReg <= ld_last;
          end
        end
        WRITE: begin
          if (addrReg[1:0] != 2'b00) addr_err <= 1'b1;
        end
        FLUSH1: begin
          runCnt <= '0;
        end
        RUN: begin
          runCnt <= runCnt + 1'b1;
          if (resultHit) begin
            result       <= WriteData;
            result_valid <= 1'b1;
          end
          if (doneHit) begin
            done <= 1'b1;
          end else if (cntHit) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_host_loader.sv
`timescale 1ns/1ps
// Directed bench for cpu_host_loader: preload jobs, done filtering, timeout,
// misaligned loads and asynchronous reset in the middle of a job.
module tb_cpu_host_loader;

  localparam logic [31:0] ResAdr  = 32'h0200_0004;
  localparam logic [31:0] DoneAdr = 32'h0200_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        done;
  logic        timeout;
  logic        addr_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCnt = 0;
  int fallCyc = 0;
  logic prevCpuRst = 1'b1;
  logic [31:0] wrAdr[$];
  logic [31:0] wrDat[$];
  int          wrCyc[$];

  cpu_host_loader #(
    .RESULT_ADDR(ResAdr),
    .DONE_ADDR(DoneAdr),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .cpu_reset(cpu_reset),
    .Ext_MemWrite(Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr(Ext_DataAdr),
    .MemWrite(MemWrite),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .busy(busy),
    .result(result),
    .result_valid(result_valid),
    .done(done),
    .timeout(timeout),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (Ext_MemWrite) begin
      wrAdr.push_back(Ext_DataAdr);
      wrDat.push_back(Ext_WriteData);
      wrCyc.push_back(cyc);
    end
    if (done) doneCnt++;
    if (prevCpuRst && !cpu_reset) fallCyc = cyc;
    prevCpuRst = cpu_reset;
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clearLog();
    wrAdr.delete();
    wrDat.delete();
    wrCyc.delete();
  endtask

  task automatic startJob();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("load entry ld_ready", ld_ready, 1);
  endtask

  task automatic sendWord(input logic [31:0] a, input logic [31:0] d, input logic last,
                          input int idle);
    int n;
    repeat (idle) @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    n = 0;
    while (!ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) checkVal("ld_ready wait", ld_ready, 1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic waitRun();
    int n;
    n = 0;
    while (cpu_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkVal("run entry cpu_reset", cpu_reset, 0);
  endtask

  task automatic cpuStore(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic finishDone(input string tag);
    int d0;
    d0 = doneCnt;
    cpuStore(DoneAdr, 1);
    checkVal({tag, " done"}, done, 1);
    checkVal({tag, " cpu_reset after"}, cpu_reset, 1);
    checkVal({tag, " busy after"}, busy, 0);
    @(negedge clk);
    checkVal({tag, " done pulse end"}, done, 0);
    checkVal({tag, " done count"}, doneCnt - d0, 1);
  endtask

  task automatic sumJob(input string tag);
    clearLog();
    startJob();
    sendWord(32'h0200_0000, 20, 1'b0, 0);
    sendWord(32'h0200_0004, 0, 1'b0, 0);
    sendWord(32'h0200_0008, 0, 1'b1, 0);
    waitRun();
    @(negedge clk);
    checkVal({tag, " write count"}, wrAdr.size(), 3);
    checkVal({tag, " wr0 adr"}, wrAdr[0], 32'h0200_0000);
    checkVal({tag, " wr0 dat"}, wrDat[0], 20);
    checkVal({tag, " wr1 adr"}, wrAdr[1], 32'h0200_0004);
    checkVal({tag, " wr1 dat"}, wrDat[1], 0);
    checkVal({tag, " wr2 adr"}, wrAdr[2], 32'h0200_0008);
    checkVal({tag, " wr2 dat"}, wrDat[2], 0);
    checkVal({tag, " strobe spacing 01"}, wrCyc[1] - wrCyc[0], 3);
    checkVal({tag, " strobe spacing 12"}, wrCyc[2] - wrCyc[1], 3);
    checkVal({tag, " reset fall gap"}, fallCyc - wrCyc[2], 4);
    cpuStore(ResAdr, 210);
    checkVal({tag, " busy in run"}, busy, 1);
    finishDone(tag);
    checkVal({tag, " result"}, result, 210);
    checkVal({tag, " result_valid"}, result_valid, 1);
  endtask

  initial begin
    int n;
    int d0;
    int runStart;
    logic [31:0] expAdr;

    #1;
    checkVal("async rst cpu_reset", cpu_reset, 1);
    repeat (2) @(negedge clk);
    checkVal("rst cpu_reset", cpu_reset, 1);
    checkVal("rst ld_ready", ld_ready, 0);
    checkVal("rst busy", busy, 0);
    checkVal("rst Ext_MemWrite", Ext_MemWrite, 0);
    checkVal("rst Ext_DataAdr", Ext_DataAdr, 0);
    checkVal("rst Ext_WriteData", Ext_WriteData, 0);
    checkVal("rst result", result, 0);
    checkVal("rst result_valid", result_valid, 0);
    checkVal("rst done", done, 0);
    checkVal("rst timeout", timeout, 0);
    checkVal("rst addr_err", addr_err, 0);
    reset = 1'b1;
    @(negedge clk);

    sumJob("sum");

    // Back-pressure with stray starts in LOAD and RUN
    clearLog();
    startJob();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("bp start in load ignored", ld_ready, 1);
    for (int i = 0; i < 5; i++) begin
      sendWord(32'h0200_0010 + 32'(4 * i), 32'hA0 + 32'(i), (i == 4), $urandom_range(0, 3));
    end
    waitRun();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("bp start in run ignored", cpu_reset, 0);
    checkVal("bp write count", wrAdr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      expAdr = 32'h0200_0010 + 32'(4 * i);
      checkVal("bp wr adr", wrAdr[i], expAdr);
      checkVal("bp wr dat", wrDat[i], 32'hA0 + 32'(i));
    end
    cpuStore(ResAdr, 99);
    finishDone("bp");
    checkVal("bp result", result, 99);
    @(negedge clk);
    checkVal("bp no restart", busy, 0);

    // Done-address filtering
    startJob();
    sendWord(32'h0200_0000, 3, 1'b1, 0);
    waitRun();
    d0 = doneCnt;
    cpuStore(DoneAdr, 0);
    checkVal("filt store 0 busy", busy, 1);
    checkVal("filt store 0 cpu_reset", cpu_reset, 0);
    cpuStore(DoneAdr, 5);
    checkVal("filt store 5 busy", busy, 1);
    checkVal("filt store 5 cpu_reset", cpu_reset, 0);
    checkVal("filt no done yet", doneCnt - d0, 0);
    finishDone("filt");
    checkVal("filt result_valid", result_valid, 0);

    // Timeout
    startJob();
    sendWord(32'h0200_0000, 1, 1'b1, 0);
    waitRun();
    runStart = cyc;
    d0 = doneCnt;
    repeat (49) @(negedge clk);
    checkVal("to run cycle 49 timeout", timeout, 0);
    checkVal("to run cycle 49 cpu_reset", cpu_reset, 0);
    @(negedge clk);
    checkVal("to run cycle 50 index", cyc - runStart, 50);
    checkVal("to timeout", timeout, 1);
    checkVal("to cpu_reset", cpu_reset, 1);
    checkVal("to busy", busy, 0);
    @(negedge clk);
    checkVal("to sticky", timeout, 1);
    checkVal("to no done", doneCnt - d0, 0);
    startJob();
    checkVal("to cleared by start", timeout, 0);
    sendWord(32'h0200_0000, 1, 1'b1, 0);
    waitRun();
    finishDone("to next");

    // Misaligned load
    clearLog();
    startJob();
    sendWord(32'h0200_0006, 32'hAB, 1'b1, 0);
    checkVal("mis strobe", Ext_MemWrite, 1);
    checkVal("mis adr", Ext_DataAdr, 32'h0200_0004);
    checkVal("mis dat", Ext_WriteData, 32'hAB);
    @(negedge clk);
    checkVal("mis addr_err", addr_err, 1);
    waitRun();
    finishDone("mis");
    checkVal("mis addr_err sticky", addr_err, 1);
    startJob();
    checkVal("mis addr_err cleared", addr_err, 0);
    sendWord(32'h0200_0000, 0, 1'b1, 0);
    waitRun();
    finishDone("mis next");

    // Async reset during WRITE
    startJob();
    ld_valid = 1'b1;
    ld_addr  = 32'h0200_0000;
    ld_data  = 32'h55;
    ld_last  = 1'b0;
    n = 0;
    while (!Ext_MemWrite && n < 10) begin
      @(negedge clk);
      n++;
    end
    ld_valid = 1'b0;
    checkVal("ar write strobe", Ext_MemWrite, 1);
    #2 reset = 1'b0;
    #1;
    checkVal("ar write Ext_MemWrite", Ext_MemWrite, 0);
    checkVal("ar write Ext_DataAdr", Ext_DataAdr, 0);
    checkVal("ar write Ext_WriteData", Ext_WriteData, 0);
    checkVal("ar write cpu_reset", cpu_reset, 1);
    checkVal("ar write busy", busy, 0);
    checkVal("ar write ld_ready", ld_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Async reset during RUN
    startJob();
    sendWord(32'h0200_0000, 2, 1'b1, 0);
    waitRun();
    cpuStore(ResAdr, 7);
    checkVal("ar run result", result, 7);
    checkVal("ar run result_valid", result_valid, 1);
    #2 reset = 1'b0;
    #1;
    checkVal("ar run cpu_reset", cpu_reset, 1);
    checkVal("ar run busy", busy, 0);
    checkVal("ar run result", result, 0);
    checkVal("ar run result_valid", result_valid, 0);
    checkVal("ar run done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    sumJob("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
